// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: WIDTH-bit operands are resolved in STAGES equal carry-chained
// slices, one slice per stage, with valid/ready flow control and per-stage bubble collapsing.
module pipe_addsub #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_a_i,
    input  logic [WIDTH-1:0] in_b_i,
    input  logic             in_cin_i,
    input  logic             in_sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_sum_o,
    output logic             out_cout_o,
    output logic             out_ovf_o
);

    localparam int unsigned SL = (STAGES == 0) ? 1 : WIDTH / STAGES;

    if (WIDTH == 0 || STAGES == 0 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_addsub: requires 1 <= STAGES <= WIDTH and WIDTH divisible by STAGES");
    end

    // Per-stage registers; operands already carry the inverted B for subtraction.
    logic [STAGES-1:0]            valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] sum_q, sum_d;
    logic [STAGES-1:0]            carry_q, carry_d;

    // What each stage would capture: the upstream beat for stage 0, the previous stage otherwise.
    logic [STAGES-1:0]            s_valid;
    logic [STAGES-1:0][WIDTH-1:0] s_a;
    logic [STAGES-1:0][WIDTH-1:0] s_b;
    logic [STAGES-1:0][WIDTH-1:0] s_sum;
    logic [STAGES-1:0]            s_c;
    logic [STAGES-1:0]            en;
    logic [SL:0]                  slice;

    always_comb begin
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        s_valid = '0;
        s_a     = '0;
        s_b     = '0;
        s_sum   = '0;
        s_c     = '0;
        en      = '0;
        slice   = '0;

        // A stage may load when it is empty or its contents move on; ripples back from the output.
        en[STAGES-1] = !valid_q[STAGES-1] || out_ready_i;
        for (int unsigned k = STAGES - 1; k > 0; k--) begin
            en[k-1] = !valid_q[k-1] || en[k];
        end

        s_valid[0] = in_valid_i;
        s_a[0]     = in_a_i;
        s_b[0]     = in_sub_i ? ~in_b_i : in_b_i;
        s_sum[0]   = '0;
        s_c[0]     = in_cin_i ^ in_sub_i;
        for (int unsigned k = 1; k < STAGES; k++) begin
            s_valid[k] = valid_q[k-1];
            s_a[k]     = a_q[k-1];
            s_b[k]     = b_q[k-1];
            s_sum[k]   = sum_q[k-1];
            s_c[k]     = carry_q[k-1];
        end

        for (int unsigned k = 0; k < STAGES; k++) begin
            slice = {1'b0, s_a[k][k*SL +: SL]} + {1'b0, s_b[k][k*SL +: SL]}
                  + {{SL{1'b0}}, s_c[k]};
            if (en[k]) begin
                valid_d[k] = s_valid[k];
                // Bubbles only clear the valid bit so idle stages keep their data still.
                if (s_valid[k]) begin
                    a_d[k]                = s_a[k];
                    b_d[k]                = s_b[k];
                    sum_d[k]              = s_sum[k];
                    sum_d[k][k*SL +: SL]  = slice[SL-1:0];
                    carry_d[k]            = slice[SL];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // The last stage keeps its full operands only for their sign bits.
    logic unused_last_operands;
    assign unused_last_operands = ^{a_q[STAGES-1], b_q[STAGES-1]};

    assign in_ready_o  = en[0];
    assign out_valid_o = valid_q[STAGES-1];
    assign out_sum_o   = sum_q[STAGES-1];
    assign out_cout_o  = carry_q[STAGES-1];
    assign out_ovf_o   = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
                      && (sum_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_pipe_addsub.sv
// Bench for pipe_addsub: directed vector table on an 8-bit/2-stage instance, backpressure and
// reset sequences, plus an exhaustive back-to-back sweep on a 4-bit/4-stage instance.
module tb_pipe_addsub;

    localparam int unsigned S  = 2;
    localparam int unsigned S4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [7:0] a, b, sum;
    logic       in_valid4, in_ready4, cin4, sub4, out_valid4, out_ready4, cout4, ovf4;
    logic [3:0] a4, b4, sum4;

    pipe_addsub #(.WIDTH(8), .STAGES(S)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_a_i(a), .in_b_i(b), .in_cin_i(cin), .in_sub_i(sub),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_sum_o(sum), .out_cout_o(cout), .out_ovf_o(ovf)
    );

    pipe_addsub #(.WIDTH(4), .STAGES(S4)) u_dut4 (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid4), .in_ready_o(in_ready4),
        .in_a_i(a4), .in_b_i(b4), .in_cin_i(cin4), .in_sub_i(sub4),
        .out_valid_o(out_valid4), .out_ready_i(out_ready4),
        .out_sum_o(sum4), .out_cout_o(cout4), .out_ovf_o(ovf4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;
    vec_t vecs [12];

    // Returns {ovf, cout, sum}.
    function automatic logic [9:0] ref8(input logic [7:0] ra, input logic [7:0] rb,
                                        input logic rcin, input logic rsub);
        logic [7:0] bp;
        logic [8:0] r;
        bp = rsub ? ~rb : rb;
        r  = {1'b0, ra} + {1'b0, bp} + {8'd0, rcin ^ rsub};
        return {(ra[7] == bp[7]) && (r[7] != ra[7]), r};
    endfunction

    function automatic logic [5:0] ref4(input logic [3:0] ra, input logic [3:0] rb,
                                        input logic rcin, input logic rsub);
        logic [3:0] bp;
        logic [4:0] r;
        bp = rsub ? ~rb : rb;
        r  = {1'b0, ra} + {1'b0, bp} + {4'd0, rcin ^ rsub};
        return {(ra[3] == bp[3]) && (r[3] != ra[3]), r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_beat(input int i);
        a   = 8'(i * 31 + 3);
        b   = 8'(i * 53 + 7);
        cin = i[1];
        sub = i[0];
    endtask

    int         lat, sent, got, ex_err, ex_got, stale;
    logic [9:0] expq [$];
    logic [9:0] held, exp8;
    logic       held_ok, exp_v;
    logic [9:0] combo;
    logic [5:0] exp4;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        in_valid4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1;

        //            a      b      cin   sub   sum    cout  ovf
        vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
        vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[4]  = '{8'h05, 8'h02, 1'b1, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[5]  = '{8'h0F, 8'h01, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0};
        vecs[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[8]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
        vecs[10] = '{8'h3C, 8'h44, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[11] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'({ovf, cout, sum}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors, one at a time, checking latency and result.
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            a = vecs[i].a; b = vecs[i].b; cin = vecs[i].cin; sub = vecs[i].sub;
            in_valid = 1'b1;
            #1;
            check($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'd1);
            @(posedge clk);
            #1 in_valid = 1'b0;
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 20);
            check($sformatf("vec%0d_latency", i), 32'(lat), S);
            check($sformatf("vec%0d_result", i), 32'({ovf, cout, sum}),
                  32'({vecs[i].ovf, vecs[i].cout, vecs[i].sum}));
        end

        // Backpressure: 10 beats, out_ready low for the first 5 cycles.
        @(negedge clk);
        sent = 0; got = 0; held_ok = 1'b0;
        in_valid = 1'b1;
        set_beat(0);
        for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
            out_ready = (cyc >= 5);
            #1;
            if (cyc == 4) begin
                check("bp_in_ready_low", 32'(in_ready), 32'd0);
                check("bp_fill_count", 32'(sent), S);
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL bp_extra_beat: got 0x%0h, expected no beat", {ovf, cout, sum});
                end else begin
                    exp8 = expq.pop_front();
                    check($sformatf("bp_beat%0d", got), 32'({ovf, cout, sum}), 32'(exp8));
                end
                got++;
                held_ok = 1'b0;
            end else if (out_valid) begin
                if (held_ok) check("bp_stall_stable", 32'({ovf, cout, sum}), 32'(held));
                held    = {ovf, cout, sum};
                held_ok = 1'b1;
            end
            if (in_valid && in_ready) begin
                expq.push_back(ref8(a, b, cin, sub));
                sent++;
            end
            @(negedge clk);
            if (sent < 10) set_beat(sent);
            else in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("bp_all_received", 32'(got), 32'd10);

        // Exhaustive back-to-back sweep on the 4-bit, 4-stage instance.
        ex_err = 0; ex_got = 0;
        for (int c = 0; c < 1024 + 6; c++) begin
            if (c < 1024) begin
                in_valid4 = 1'b1;
                combo = 10'(c);
                {sub4, cin4, b4, a4} = combo;
            end else begin
                in_valid4 = 1'b0;
            end
            #1;
            if (c < 1024 && !in_ready4) ex_err++;
            exp_v = (c >= 4) && (c - 4 < 1024);
            if (out_valid4 !== exp_v) ex_err++;
            if (exp_v && out_valid4) begin
                combo = 10'(c - 4);
                exp4  = ref4(combo[3:0], combo[7:4], combo[8], combo[9]);
                if ({ovf4, cout4, sum4} !== exp4) ex_err++;
                ex_got++;
            end
            @(negedge clk);
        end
        check("ex4_errors", 32'(ex_err), 32'd0);
        check("ex4_results", 32'(ex_got), 32'd1024);

        // Reset with a full, stalled pipe.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_pre_full", 32'({out_valid, in_ready}), 32'b10);
        check("rst_pre_sum", 32'(sum), 32'h46);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(out_valid), 32'd0);
        check("rst_async_outputs", 32'({ovf, cout, sum}), 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        check("rst_no_stale", 32'(stale), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
